// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV32M op codes,
// FSM state encoding and the CALC iteration count helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic int calc_iters(input int xlen, input int step);
    return xlen / step;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One CALC iteration: STEP shift-add (multiply) or STEP restoring-subtract
// (divide) steps on the {hi, lo} accumulator. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] work;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     r_ext;
  logic [XLEN-1:0]   rem_new;
  logic              ge;

  // Multiply: lo holds the remaining multiplier bits, hi the partial product.
  // Divide: hi is the partial remainder, quotient bits shift into lo.
  always_comb begin
    work    = acc;
    sum     = '0;
    r_ext   = '0;
    rem_new = '0;
    ge      = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (!div_mode) begin
        sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, operand} : '0);
        work = {sum, work[XLEN-1:1]};
      end else begin
        r_ext   = work[2*XLEN-1:XLEN-1];
        ge      = (r_ext >= {1'b0, operand});
        rem_new = r_ext[XLEN-1:0] - operand;
        if (ge)
          work = {rem_new, work[XLEN-2:0], 1'b1};
        else
          work = {r_ext[XLEN-1:0], work[XLEN-2:0], 1'b0};
      end
    end
    acc_next = work;
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative RV32M multiply/divide unit, STEP result bits per CALC cycle.
// Optional MULDIV_FASTPATH_EN: trivial operands retire in one cycle.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int N  = calc_iters(XLEN, STEP);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_n;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [CW-1:0]     cnt_q;

  logic              a_neg, b_neg, is_div, neg_d;
  logic [XLEN-1:0]   abs_a, abs_b, opnd_init;
  logic [2*XLEN-1:0] acc_init, prod;
  logic [XLEN-1:0]   fix_res;
  logic              load_en, fast_en, calc_en, fix_en;
  logic              fast;
  logic [XLEN-1:0]   fast_res;

  // Operands become magnitudes; the single result-sign flag is decided here.
  // A zero divisor never flips the quotient so it stays all ones.
  always_comb begin
    a_neg  = srca[XLEN-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    b_neg  = srcb[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    abs_a  = a_neg ? -srca : srca;
    abs_b  = b_neg ? -srcb : srcb;
    is_div = op[2];
    if (!is_div)
      neg_d = a_neg ^ b_neg;
    else if (op[1])
      neg_d = a_neg;
    else
      neg_d = (a_neg ^ b_neg) && (srcb != '0);
    if (is_div) begin
      acc_init  = {{XLEN{1'b0}}, abs_a};
      opnd_init = abs_b;
    end else begin
      acc_init  = {{XLEN{1'b0}}, abs_b};
      opnd_init = abs_a;
    end
  end

`ifdef MULDIV_FASTPATH_EN
  logic ovf;
  always_comb begin
    ovf      = (op == OP_DIV || op == OP_REM) && (srca == MIN_VAL) && (srcb == '1);
    fast     = (srca == '0) || (srcb == '0) || ovf;
    fast_res = '0;
    if (is_div && srcb == '0)
      fast_res = op[1] ? srca : '1;
    else if (ovf && op == OP_DIV)
      fast_res = MIN_VAL;
  end
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  muldiv_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .div_mode (op_q[2]),
    .acc_next (acc_step)
  );

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                      fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_n = state;
    load_en = 1'b0;
    fast_en = 1'b0;
    calc_en = 1'b0;
    fix_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && fast) begin
          fast_en = 1'b1;
        end else if (start) begin
          load_en = 1'b1;
          state_n = S_CALC;
        end
      end
      S_CALC: begin
        calc_en = 1'b1;
        if (cnt_q == '0)
          state_n = S_FIX;
      end
      S_FIX: begin
        fix_en  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done   <= 1'b0;
      res    <= '0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (load_en) begin
        op_q   <= op;
        neg_q  <= neg_d;
        opnd_q <= opnd_init;
        acc_q  <= acc_init;
        cnt_q  <= CNT_LOAD;
      end
      if (fast_en) begin
        res  <= fast_res;
        done <= 1'b1;
      end
      if (calc_en) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CW'(1);
      end
      if (fix_en) begin
        res  <= fix_res;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: STEP=1 and STEP=4 instances against a
// 64-bit arithmetic reference model, directed corner cases plus random ops.
module tb_iter_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iter_muldiv #(.XLEN(32), .STEP(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .op(op), .srca(srca), .srcb(srcb),
    .busy(busy1), .done(done1), .res(res1)
  );

  iter_muldiv #(.XLEN(32), .STEP(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .op(op), .srca(srca), .srcb(srcb),
    .busy(busy4), .done(done4), .res(res4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result straight from RV32M semantics using 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      OP_MUL:    begin p = 64'(ua * ub); return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isFast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    return (a == 0) || (b == 0) ||
           ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int expLat(input bit use4, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (isFast(o, a, b)) return 1;
    return use4 ? 32 / 4 + 2 : 32 + 2;
  endfunction

  // Issues one op (at the next falling edge, or immediately when atNeg=0) and
  // waits for done; lat is the cycle index of done relative to the accept cycle.
  task automatic applyStimulus(input bit use4, input bit atNeg, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] r);
    if (atNeg) @(negedge clk);
    op = o; srca = a; srcb = b;
    start1 = !use4; start4 = use4;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    lat = 1;
    checkOutput("busy_cycle1", {31'b0, use4 ? busy4 : busy1}, {31'b0, !isFast(o, a, b)});
    while (!(use4 ? done4 : done1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("done_seen", {31'b0, use4 ? done4 : done1}, 32'd1);
    r = use4 ? res4 : res1;
  endtask

  task automatic runOp(input bit use4, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat;
    logic [31:0] r;
    applyStimulus(use4, 1'b1, o, a, b, lat, r);
    checkOutput($sformatf("res op%0d %h,%h", o, a, b), r, exp);
    checkOutput($sformatf("latency op%0d", o), 32'(lat), 32'(expLat(use4, o, a, b)));
    checkOutput("busy_in_done", {31'b0, use4 ? busy4 : busy1}, 32'd0);
    @(posedge clk); #1;
    checkOutput("done_pulse_width", {31'b0, use4 ? done4 : done1}, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] r, a, b;
    logic [2:0] o;

    #22;
    checkOutput("reset_busy", {31'b0, busy1}, 32'd0);
    checkOutput("reset_done", {31'b0, done1}, 32'd0);
    checkOutput("reset_res", res1, 32'd0);
    @(negedge clk); rstn = 1'b1;

    $display("[TB] directed corner cases");
    runOp(0, OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    runOp(0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp(0, OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    runOp(0, OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    runOp(0, OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    runOp(0, OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    runOp(0, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp(0, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    runOp(0, OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    runOp(0, OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    runOp(0, OP_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF);
    runOp(0, OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);

    $display("[TB] start while busy, then back-to-back issue");
    @(negedge clk);
    op = OP_DIVU; srca = 32'd100; srcb = 32'd7; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; lat = 1;
    repeat (9) begin @(posedge clk); #1; lat++; end
    op = OP_MUL; srca = 32'd3; srcb = 32'd3; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; lat++;
    while (!done1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checkOutput("busy_ignore_done", {31'b0, done1}, 32'd1);
    checkOutput("busy_ignore_res", res1, 32'd14);
    checkOutput("busy_ignore_lat", 32'(lat), 32'd34);
    applyStimulus(0, 1'b0, OP_DIVU, 32'd200, 32'd7, lat, r);
    checkOutput("b2b_res", r, 32'd28);
    checkOutput("b2b_lat", 32'(lat), 32'd34);

    $display("[TB] random ops, STEP=1");
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7)); a = pickOperand(); b = pickOperand();
      runOp(0, o, a, b, refModel(o, a, b));
    end
    $display("[TB] random ops, STEP=4");
    for (int i = 0; i < 20; i++) begin
      o = 3'($urandom_range(0, 7)); a = pickOperand(); b = pickOperand();
      runOp(1, o, a, b, refModel(o, a, b));
    end

    $display("[TB] reset mid-operation");
    runOp(0, OP_MUL, 32'd6, 32'd7, 32'd42);
    @(negedge clk);
    op = OP_MUL; srca = 32'h1234; srcb = 32'h5678; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'b0, busy1}, 32'd0);
    checkOutput("midreset_done", {31'b0, done1}, 32'd0);
    checkOutput("midreset_res", res1, 32'd0);
    checkOutput("midreset_res4", res4, 32'd0);
    @(negedge clk); rstn = 1'b1;
    runOp(1, OP_MUL, 32'd3, 32'd5, 32'd15);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("discarded_no_done", {31'b0, done1}, 32'd0);
    checkOutput("discarded_res", res1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
